// File: rtl/vu_rnum_pipe.sv
// vu_rnum_pipe: register-number pipeline for one vector unit (RD -> EX -> ACC -> WB).
// Carries destination/load register numbers and write qualifiers down the pipe,
// drives the ACC/WB register-file address controls, and raises RAW hazards in RD.
module vu_rnum_pipe (
  input  logic       clk,
  input  logic       reset_l,
  input  logic       rd_valid,
  input  logic [4:0] rd_vs,
  input  logic [4:0] rd_vt,
  input  logic       rd_uses_vs,
  input  logic       rd_uses_vt,
  input  logic [4:0] rd_vd,
  input  logic       rd_wr_en,
  input  logic       rd_div_type,
  input  logic [2:0] rd_div_elem,
  input  logic       rd_ld,
  input  logic [4:0] rd_ld_rnum,
  input  logic [1:0] rd_ld_bwe,
  input  logic       rd_xpose,
  input  logic       stall,
  input  logic       kill_ex,
  output logic       rd_accept,
  output logic       rd_hazard,
  output logic [4:0] ld_rnum,
  output logic       xpose,
  output logic [4:0] vd,
  output logic       wbv_wr_en,
  output logic [1:0] bwe,
  output logic       wb_div_type,
  output logic [2:0] wb_div_elem
);

  typedef struct packed {
    logic       valid;
    logic [4:0] vd;
    logic       wr_en;
    logic       div_type;
    logic [2:0] div_elem;
    logic       ld;
    logic [4:0] ld_rnum;
    logic [1:0] bwe;
    logic       xpose;
  } stage_t;

  // WB has no consumer for the load register number or transpose flag
  // (those are used at ACC), so they are not carried into the last stage.
  typedef struct packed {
    logic       valid;
    logic [4:0] vd;
    logic       wr_en;
    logic       div_type;
    logic [2:0] div_elem;
    logic       ld;
    logic [1:0] bwe;
  } wb_stage_t;

  stage_t    ex_q, ex_d, acc_q, acc_d, rd_stage;
  wb_stage_t wb_q, wb_d;
  logic      vs_hit, vt_hit;

  // True when an in-flight stage will write register r (datapath or load).
  function automatic logic stage_writes(stage_t s, logic [4:0] r);
    return s.valid & ((s.wr_en & (s.vd == r)) | (s.ld & (s.ld_rnum == r)));
  endfunction

  // RAW hazard against EX and ACC only; WB writes before RD reads the same cycle.
  always_comb begin
    vs_hit    = rd_uses_vs & (stage_writes(ex_q, rd_vs) | stage_writes(acc_q, rd_vs));
    vt_hit    = rd_uses_vt & (stage_writes(ex_q, rd_vt) | stage_writes(acc_q, rd_vt));
    rd_hazard = reset_l & rd_valid & (vs_hit | vt_hit);
    rd_accept = reset_l & rd_valid & ~rd_hazard & ~stall;
  end

  // Pack the RD fields into a stage record; valid reflects acceptance.
  always_comb begin
    rd_stage          = '0;
    rd_stage.valid    = rd_accept;
    rd_stage.vd       = rd_vd;
    rd_stage.wr_en    = rd_wr_en;
    rd_stage.div_type = rd_div_type;
    rd_stage.div_elem = rd_div_elem;
    rd_stage.ld       = rd_ld;
    rd_stage.ld_rnum  = rd_ld_rnum;
    rd_stage.bwe      = rd_ld_bwe;
    rd_stage.xpose    = rd_xpose;
  end

  // Next-state: hold on stall, otherwise shift; a kill always drops the EX entry.
  always_comb begin
    ex_d  = ex_q;
    acc_d = acc_q;
    wb_d  = wb_q;
    if (stall) begin
      ex_d.valid = ex_q.valid & ~kill_ex;
    end else begin
      wb_d.valid    = acc_q.valid;
      wb_d.vd       = acc_q.vd;
      wb_d.wr_en    = acc_q.wr_en;
      wb_d.div_type = acc_q.div_type;
      wb_d.div_elem = acc_q.div_elem;
      wb_d.ld       = acc_q.ld;
      wb_d.bwe      = acc_q.bwe;
      acc_d         = ex_q;
      acc_d.valid   = ex_q.valid & ~kill_ex;
      ex_d          = rd_stage;
    end
  end

  // Stage registers with synchronous active-low reset that discards everything in flight.
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      ex_q  <= '0;
      acc_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      acc_q <= acc_d;
      wb_q  <= wb_d;
    end
  end

  // Output gating: every field reads as zero when its stage is empty.
  always_comb begin
    ld_rnum     = (acc_q.valid & acc_q.ld) ? acc_q.ld_rnum : 5'd0;
    xpose       = acc_q.valid & acc_q.ld & acc_q.xpose;
    vd          = wb_q.valid ? wb_q.vd : 5'd0;
    wbv_wr_en   = wb_q.valid & wb_q.wr_en;
    bwe         = (wb_q.valid & wb_q.ld) ? wb_q.bwe : 2'b00;
    wb_div_type = wb_q.valid & wb_q.div_type;
    wb_div_elem = wb_q.valid ? wb_q.div_elem : 3'd0;
  end

endmodule

// File: tb/tb_vu_rnum_pipe.sv
// tb_vu_rnum_pipe: table-driven vectors with a due-cycle scoreboard for isolated
// instructions, plus hand-written sequences for hazards, stall, kill and reset.
module tb_vu_rnum_pipe;

  logic       clk = 1'b0;
  logic       reset_l;
  logic       rd_valid;
  logic [4:0] rd_vs, rd_vt, rd_vd, rd_ld_rnum;
  logic       rd_uses_vs, rd_uses_vt, rd_wr_en, rd_div_type, rd_ld, rd_xpose;
  logic [2:0] rd_div_elem;
  logic [1:0] rd_ld_bwe;
  logic       stall, kill_ex;
  logic       rd_accept, rd_hazard, xpose, wbv_wr_en, wb_div_type;
  logic [4:0] ld_rnum, vd;
  logic [1:0] bwe;
  logic [2:0] wb_div_elem;

  vu_rnum_pipe dut (
    .clk(clk), .reset_l(reset_l), .rd_valid(rd_valid), .rd_vs(rd_vs), .rd_vt(rd_vt),
    .rd_uses_vs(rd_uses_vs), .rd_uses_vt(rd_uses_vt), .rd_vd(rd_vd), .rd_wr_en(rd_wr_en),
    .rd_div_type(rd_div_type), .rd_div_elem(rd_div_elem), .rd_ld(rd_ld),
    .rd_ld_rnum(rd_ld_rnum), .rd_ld_bwe(rd_ld_bwe), .rd_xpose(rd_xpose), .stall(stall),
    .kill_ex(kill_ex), .rd_accept(rd_accept), .rd_hazard(rd_hazard), .ld_rnum(ld_rnum),
    .xpose(xpose), .vd(vd), .wbv_wr_en(wbv_wr_en), .bwe(bwe), .wb_div_type(wb_div_type),
    .wb_div_elem(wb_div_elem)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] vd;
    logic       wr;
    logic       dt;
    logic [2:0] de;
    logic       ld;
    logic [4:0] ldr;
    logic [1:0] bw;
    logic       xp;
    logic [4:0] e_ldr;
    logic       e_xp;
    logic [4:0] e_vd;
    logic       e_wr;
    logic [1:0] e_bw;
    logic       e_dt;
    logic [2:0] e_de;
  } vec_t;

  typedef struct packed {
    int         due;
    logic [4:0] ldr;
    logic       xp;
  } acc_exp_t;

  typedef struct packed {
    int         due;
    logic [4:0] vd;
    logic       wr;
    logic [1:0] bw;
    logic       dt;
    logic [2:0] de;
  } wb_exp_t;

  vec_t     vecs [8];
  acc_exp_t acc_sb[$];
  wb_exp_t  wb_sb[$];
  int       total = 0;
  int       bad = 0;
  int       edge_cnt = 0;
  bit       mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // Compare ACC/WB outputs against the scoreboard head when due, else expect idle zeros.
  task automatic monitor();
    if (acc_sb.size() != 0 && acc_sb[0].due == edge_cnt) begin
      chk("acc_ld_rnum", {27'd0, ld_rnum}, {27'd0, acc_sb[0].ldr});
      chk("acc_xpose", {31'd0, xpose}, {31'd0, acc_sb[0].xp});
      void'(acc_sb.pop_front());
    end else begin
      chk("acc_idle", {26'd0, ld_rnum, xpose}, 32'd0);
    end
    if (wb_sb.size() != 0 && wb_sb[0].due == edge_cnt) begin
      chk("wb_vd", {27'd0, vd}, {27'd0, wb_sb[0].vd});
      chk("wb_wr_en", {31'd0, wbv_wr_en}, {31'd0, wb_sb[0].wr});
      chk("wb_bwe", {30'd0, bwe}, {30'd0, wb_sb[0].bw});
      chk("wb_div_type", {31'd0, wb_div_type}, {31'd0, wb_sb[0].dt});
      chk("wb_div_elem", {29'd0, wb_div_elem}, {29'd0, wb_sb[0].de});
      $display("wb txn edge=%0d vd=%0d wr=%0b bwe=%b div=%0b/%0d", edge_cnt, vd, wbv_wr_en, bwe,
               wb_div_type, wb_div_elem);
      void'(wb_sb.pop_front());
    end else begin
      chk("wb_idle", {20'd0, vd, wbv_wr_en, bwe, wb_div_type, wb_div_elem}, 32'd0);
    end
  endtask

  task automatic post();
    @(posedge clk);
    edge_cnt++;
    #1;
  endtask

  task automatic tick();
    @(negedge clk);
    if (mon_en) monitor();
    post();
  endtask

  task automatic idle_in();
    rd_valid = 0; rd_vs = 0; rd_vt = 0; rd_uses_vs = 0; rd_uses_vt = 0;
    rd_vd = 0; rd_wr_en = 0; rd_div_type = 0; rd_div_elem = 0;
    rd_ld = 0; rd_ld_rnum = 0; rd_ld_bwe = 0; rd_xpose = 0;
  endtask

  task automatic drive(input logic [4:0] d, input logic wr, input logic dt, input logic [2:0] de,
                       input logic l, input logic [4:0] lr, input logic [1:0] bw, input logic xp);
    idle_in();
    rd_valid = 1; rd_vd = d; rd_wr_en = wr; rd_div_type = dt; rd_div_elem = de;
    rd_ld = l; rd_ld_rnum = lr; rd_ld_bwe = bw; rd_xpose = xp;
  endtask

  task automatic drain();
    idle_in();
    repeat (4) post();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int hz;
    int acc;
    int cnt;
    //            vd  wr dt de  ld ldr bw     xp | e_ldr e_xp e_vd e_wr e_bw  e_dt e_de
    vecs[0] = '{5'd7,  1, 0, 3'd0, 0, 5'd0,  2'b00, 0, 5'd0,  0, 5'd7,  1, 2'b00, 0, 3'd0};
    vecs[1] = '{5'd3,  0, 0, 3'd0, 1, 5'd12, 2'b10, 1, 5'd12, 1, 5'd3,  0, 2'b10, 0, 3'd0};
    vecs[2] = '{5'd0,  1, 0, 3'd0, 0, 5'd0,  2'b00, 0, 5'd0,  0, 5'd0,  1, 2'b00, 0, 3'd0};
    vecs[3] = '{5'd4,  1, 1, 3'd3, 0, 5'd0,  2'b00, 0, 5'd0,  0, 5'd4,  1, 2'b00, 1, 3'd3};
    vecs[4] = '{5'd31, 1, 0, 3'd0, 0, 5'd25, 2'b11, 1, 5'd0,  0, 5'd31, 1, 2'b00, 0, 3'd0};
    vecs[5] = '{5'd0,  0, 0, 3'd0, 1, 5'd0,  2'b01, 0, 5'd0,  0, 5'd0,  0, 2'b01, 0, 3'd0};
    vecs[6] = '{5'd16, 0, 0, 3'd5, 0, 5'd9,  2'b00, 0, 5'd0,  0, 5'd16, 0, 2'b00, 0, 3'd5};
    vecs[7] = '{5'd31, 1, 1, 3'd7, 1, 5'd31, 2'b11, 1, 5'd31, 1, 5'd31, 1, 2'b11, 1, 3'd7};

    // Reset with an instruction presented: nothing may be accepted or flagged.
    idle_in();
    stall = 0; kill_ex = 0; reset_l = 0;
    rd_valid = 1; rd_uses_vs = 1;
    post();
    post();
    @(negedge clk);
    chk("rst_accept", {31'd0, rd_accept}, 32'd0);
    chk("rst_hazard", {31'd0, rd_hazard}, 32'd0);
    chk("rst_outputs", {15'd0, ld_rnum, xpose, vd, wbv_wr_en, bwe, wb_div_type, wb_div_elem}, 32'd0);
    post();
    reset_l = 1;
    idle_in();
    post();

    // Table phase: back-to-back independent instructions through the scoreboard.
    mon_en = 1;
    foreach (vecs[i]) begin
      drive(vecs[i].vd, vecs[i].wr, vecs[i].dt, vecs[i].de, vecs[i].ld, vecs[i].ldr,
            vecs[i].bw, vecs[i].xp);
      acc_sb.push_back('{edge_cnt + 2, vecs[i].e_ldr, vecs[i].e_xp});
      wb_sb.push_back('{edge_cnt + 3, vecs[i].e_vd, vecs[i].e_wr, vecs[i].e_bw,
                        vecs[i].e_dt, vecs[i].e_de});
      @(negedge clk);
      chk("tbl_accept", {31'd0, rd_accept}, 32'd1);
      monitor();
      post();
    end
    idle_in();
    for (int i = 0; i < 10 && (wb_sb.size() != 0 || acc_sb.size() != 0); i++) tick();
    chk("sb_drained", wb_sb.size() + acc_sb.size(), 32'd0);
    tick();
    tick();
    mon_en = 0;

    // EX-distance hazard: producer vd=5, consumer reads vs=5 -> two bubbles.
    drive(5'd5, 1, 0, 3'd0, 0, 5'd0, 2'b00, 0);
    post();
    drive(5'd1, 0, 0, 3'd0, 0, 5'd0, 2'b00, 0);
    rd_vs = 5'd5; rd_uses_vs = 1;
    hz = 0; acc = 0;
    for (int i = 0; i < 8 && acc == 0; i++) begin
      @(negedge clk);
      if (rd_hazard) hz++;
      acc = int'(rd_accept);
      post();
    end
    chk("haz_ex_cycles", hz, 32'd2);
    chk("haz_ex_accepted", acc, 32'd1);
    drain();

    // Non-matching source is accepted immediately behind the producer.
    drive(5'd5, 1, 0, 3'd0, 0, 5'd0, 2'b00, 0);
    post();
    drive(5'd1, 0, 0, 3'd0, 0, 5'd0, 2'b00, 0);
    rd_vs = 5'd6; rd_uses_vs = 1;
    @(negedge clk);
    chk("nohaz_hazard", {31'd0, rd_hazard}, 32'd0);
    chk("nohaz_accept", {31'd0, rd_accept}, 32'd1);
    post();
    drain();

    // ACC-distance hazard via load register on vt: one bubble.
    drive(5'd2, 0, 0, 3'd0, 1, 5'd20, 2'b11, 0);
    post();
    drive(5'd2, 0, 0, 3'd0, 0, 5'd0, 2'b00, 0);
    post();
    drive(5'd1, 0, 0, 3'd0, 0, 5'd0, 2'b00, 0);
    rd_vt = 5'd20; rd_uses_vt = 1;
    hz = 0; acc = 0;
    for (int i = 0; i < 8 && acc == 0; i++) begin
      @(negedge clk);
      if (rd_hazard) hz++;
      acc = int'(rd_accept);
      post();
    end
    chk("haz_acc_cycles", hz, 32'd1);
    chk("haz_acc_accepted", acc, 32'd1);
    drain();

    // Stall while in ACC freezes ACC outputs; stall while in WB stretches the pulse.
    drive(5'd11, 1, 0, 3'd0, 1, 5'd14, 2'b11, 1);
    post();
    idle_in();
    post();
    stall = 1;
    rd_valid = 1;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        stall = 0;
        rd_valid = 0;
      end
      @(negedge clk);
      if (ld_rnum == 5'd14 && xpose && !wbv_wr_en) cnt++;
      if (i == 0) chk("stall_no_accept", {31'd0, rd_accept}, 32'd0);
      post();
    end
    chk("stall_acc_hold", cnt, 32'd4);
    stall = 1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) stall = 0;
      @(negedge clk);
      if (wbv_wr_en && vd == 5'd11 && bwe == 2'b11) cnt++;
      post();
    end
    chk("stall_wb_pulse", cnt, 32'd4);
    drain();

    // Kill the EX write to v9: no write ever, and the v9 reader is released.
    drive(5'd9, 1, 0, 3'd0, 0, 5'd0, 2'b00, 0);
    post();
    drive(5'd9, 0, 0, 3'd0, 0, 5'd0, 2'b00, 0);
    rd_vs = 5'd9; rd_uses_vs = 1;
    kill_ex = 1;
    @(negedge clk);
    chk("kill_pre_hazard", {31'd0, rd_hazard}, 32'd1);
    post();
    kill_ex = 0;
    @(negedge clk);
    chk("kill_post_hazard", {31'd0, rd_hazard}, 32'd0);
    chk("kill_post_accept", {31'd0, rd_accept}, 32'd1);
    post();
    idle_in();
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (wbv_wr_en) cnt++;
      post();
    end
    chk("kill_no_write", cnt, 32'd0);

    // Kill under stall also removes the EX entry.
    drive(5'd10, 1, 0, 3'd0, 0, 5'd0, 2'b00, 0);
    post();
    idle_in();
    stall = 1; kill_ex = 1;
    post();
    stall = 0; kill_ex = 0;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (wbv_wr_en || vd != 5'd0) cnt++;
      post();
    end
    chk("kill_stall_no_write", cnt, 32'd0);

    // Divide op reset while in ACC: WB never shows it.
    drive(5'd4, 1, 1, 3'd3, 0, 5'd0, 2'b00, 0);
    post();
    idle_in();
    post();
    reset_l = 0;
    post();
    reset_l = 1;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (wb_div_type || wb_div_elem != 3'd0 || wbv_wr_en) cnt++;
      post();
    end
    chk("rst_mid_div", cnt, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
